// File: rtl/wb_loader_pkg.sv
// Shared definitions for the byte-stream Wishbone loader: command and response
// byte codes, FSM state encoding and timeout counter sizing.
package wb_loader_pkg;

    // Command opcodes (first byte of every host command)
    localparam logic [7:0] OP_WRITE    = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ     = 8'h52;  // 'R'
    localparam logic [7:0] OP_HOLD     = 8'h48;  // 'H'
    localparam logic [7:0] OP_GO       = 8'h47;  // 'G'

    // Response status bytes
    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_TIMEOUT = 8'h45;  // 'E'
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_t;

    // Width of a counter able to hold the value `cycles` itself.
    function automatic int tmo_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_loader.sv
// Byte-stream-to-Wishbone initiator. Each host command becomes one classic
// Wishbone cycle (or a hold-line update); status and read data are returned
// on an outbound byte stream. hold_o keeps the CPU in reset while loading.
module wb_loader
    import wb_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    output logic        wb_cyc_o,
    output logic        wb_strobe_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    output logic        hold_o,
    output logic        busy
);

    localparam int CNT_W = tmo_width(TIMEOUT_CYCLES);
    // Counter value in the last strobe cycle allowed before the cycle is
    // abandoned: the counter is 0 in the first strobe cycle, so strobe is
    // high for exactly TIMEOUT_CYCLES cycles when no ack arrives.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg;
    logic [1:0]         byte_cnt_reg;   // field byte index within ADDR/DATA
    logic               is_write_reg;   // current command is a write
    logic [CNT_W-1:0]   tmo_cnt_reg;    // strobe cycles elapsed without ack
    logic [31:0]        rd_data_reg;    // captured read data, shifted out LSB first
    logic [2:0]         resp_left_reg;  // response bytes still to send after tx_data

    logic rx_fire;
    logic tx_fire;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;

    // Command FSM: byte assembly, bus cycle, timeout and response sequencing.
    // All outputs are registered and updated alongside the state transitions.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            byte_cnt_reg  <= 2'd0;
            is_write_reg  <= 1'b0;
            tmo_cnt_reg   <= '0;
            rd_data_reg   <= 32'd0;
            resp_left_reg <= 3'd0;
            rx_ready      <= 1'b1;
            busy          <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'd0;
            wb_addr_o     <= 32'd0;
            wb_data_o     <= 32'd0;
            wb_cyc_o      <= 1'b0;
            wb_strobe_o   <= 1'b0;
            wb_we_o       <= 1'b0;
            hold_o        <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rx_fire) begin
                        busy         <= 1'b1;
                        byte_cnt_reg <= 2'd0;
                        case (rx_data)
                            OP_WRITE, OP_READ: begin
                                is_write_reg <= (rx_data == OP_WRITE);
                                state_reg    <= ADDR;
                            end
                            OP_HOLD, OP_GO: begin
                                hold_o        <= (rx_data == OP_HOLD);
                                rx_ready      <= 1'b0;
                                tx_valid      <= 1'b1;
                                tx_data       <= RSP_OK;
                                resp_left_reg <= 3'd0;
                                state_reg     <= RESP;
                            end
                            default: begin
                                rx_ready      <= 1'b0;
                                tx_valid      <= 1'b1;
                                tx_data       <= RSP_UNKNOWN;
                                resp_left_reg <= 3'd0;
                                state_reg     <= RESP;
                            end
                        endcase
                    end
                end

                ADDR: begin
                    if (rx_fire) begin
                        // Little-endian: first byte ends up in bits [7:0]
                        wb_addr_o    <= {rx_data, wb_addr_o[31:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            if (is_write_reg) begin
                                state_reg <= DATA;
                            end else begin
                                rx_ready    <= 1'b0;
                                wb_cyc_o    <= 1'b1;
                                wb_strobe_o <= 1'b1;
                                wb_we_o     <= 1'b0;
                                tmo_cnt_reg <= '0;
                                state_reg   <= BUS;
                            end
                        end
                    end
                end

                DATA: begin
                    if (rx_fire) begin
                        wb_data_o    <= {rx_data, wb_data_o[31:8]};
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            rx_ready    <= 1'b0;
                            wb_cyc_o    <= 1'b1;
                            wb_strobe_o <= 1'b1;
                            wb_we_o     <= 1'b1;
                            tmo_cnt_reg <= '0;
                            state_reg   <= BUS;
                        end
                    end
                end

                BUS: begin
                    // Ack takes priority over the timeout in the final cycle
                    if (wb_ack_i) begin
                        wb_cyc_o    <= 1'b0;
                        wb_strobe_o <= 1'b0;
                        wb_we_o     <= 1'b0;
                        if (!is_write_reg) begin
                            rd_data_reg <= wb_data_i;
                        end
                        tx_valid      <= 1'b1;
                        tx_data       <= RSP_OK;
                        resp_left_reg <= is_write_reg ? 3'd0 : 3'd4;
                        state_reg     <= RESP;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        wb_cyc_o      <= 1'b0;
                        wb_strobe_o   <= 1'b0;
                        wb_we_o       <= 1'b0;
                        tx_valid      <= 1'b1;
                        tx_data       <= RSP_TIMEOUT;
                        resp_left_reg <= 3'd0;
                        state_reg     <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                RESP: begin
                    // tx_data only moves on a completed handshake
                    if (tx_fire) begin
                        if (resp_left_reg == 3'd0) begin
                            tx_valid  <= 1'b0;
                            rx_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            tx_data       <= rd_data_reg[7:0];
                            rd_data_reg   <= {8'd0, rd_data_reg[31:8]};
                            resp_left_reg <= resp_left_reg - 3'd1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_loader.sv
// Self-checking bench for wb_loader: a Wishbone slave model with programmable
// ack timing, a byte-stream driver and a tx scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_wb_loader;
    import wb_loader_pkg::*;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_cyc_o;
    logic        wb_strobe_o;
    logic        wb_we_o;
    logic        wb_ack_i;
    logic        hold_o;
    logic        busy;

    always #5 clock = ~clock;

    wb_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_data_i   (wb_data_i),
        .wb_cyc_o    (wb_cyc_o),
        .wb_strobe_o (wb_strobe_o),
        .wb_we_o     (wb_we_o),
        .wb_ack_i    (wb_ack_i),
        .hold_o      (hold_o),
        .busy        (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          ack_at = 0;        // strobe cycle (1-based) carrying ack; 0 = never
    bit          gap_en = 1'b0;
    int          stb_count = 0;
    int          last_stb_len = 0;
    logic        last_we = 1'b0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] mem [16];

    // Slave model: ack in the chosen strobe cycle, word memory on addr[5:2]
    always_comb wb_ack_i = wb_cyc_o && wb_strobe_o && (ack_at != 0) && (stb_count + 1 == ack_at);
    always_comb wb_data_i = mem[wb_addr_o[5:2]];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (wb_ack_i && wb_we_o) begin
            mem[wb_addr_o[5:2]] <= wb_data_o;
        end
        if (wb_cyc_o && wb_strobe_o) begin
            stb_count <= stb_count + 1;
            last_we   <= wb_we_o;
            last_addr <= wb_addr_o;
            last_data <= wb_data_o;
        end else begin
            if (stb_count != 0) last_stb_len <= stb_count;
            stb_count <= 0;
        end
    end

    // Tx scoreboard: every accepted byte must match the head of the queue
    always @(negedge clock) begin
        logic [7:0] exp_b;
        if (reset && tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got 0x%02h, required no byte", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data, exp_b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gap_en) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait: got 0, required 1 within 50 cycles");
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        $display("cmd W addr=0x%08h data=0x%08h", a, d);
        send_byte(OP_WRITE);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic send_read(input logic [31:0] a);
        $display("cmd R addr=0x%08h", a);
        send_byte(OP_READ);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    endtask

    task automatic send_op(input logic [7:0] op);
        $display("cmd op=0x%02h", op);
        send_byte(op);
    endtask

    task automatic push_read_resp(input logic [31:0] d);
        exp_q.push_back(RSP_OK);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain: got %0d bytes pending busy=%0b, required 0 pending busy=0",
                     tag, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({wb_cyc_o, wb_strobe_o, wb_we_o, tx_valid, busy, hold_o, rx_ready} !== 7'b0000011) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000011",
                     {wb_cyc_o, wb_strobe_o, wb_we_o, tx_valid, busy, hold_o, rx_ready});
        end
        checks++;
        if ({wb_addr_o, wb_data_o, tx_data} !== 72'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=0x%08h data=0x%08h tx=0x%02h, required all 0",
                     wb_addr_o, wb_data_o, tx_data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_write_read();
        ack_at = 3;
        exp_q.push_back(RSP_OK);
        send_write(32'h0000_0004, 32'h0000_000A);
        wait_idle("write");
        checks++;
        if ({last_we, last_addr, last_data} !== {1'b1, 32'h4, 32'hA}) begin
            errors++;
            $display("FAIL write_bus: got we=%b addr=0x%08h data=0x%08h, required we=1 addr=0x4 data=0xa",
                     last_we, last_addr, last_data);
        end
        checks++;
        if (last_stb_len !== 3) begin
            errors++;
            $display("FAIL write_stb_len: got %0d, required 3", last_stb_len);
        end
        push_read_resp(32'h0000_000A);
        send_read(32'h0000_0004);
        wait_idle("read");
        checks++;
        if (last_we !== 1'b0) begin
            errors++;
            $display("FAIL read_we: got %b, required 0", last_we);
        end
    endtask

    task automatic test_timeout();
        ack_at = 0;
        exp_q.push_back(RSP_TIMEOUT);
        send_read(32'h0001_0000);
        wait_idle("timeout");
        checks++;
        if (last_stb_len !== TMO) begin
            errors++;
            $display("FAIL timeout_stb_len: got %0d, required %0d", last_stb_len, TMO);
        end
        // Ack in the very cycle the limit is reached still succeeds
        ack_at = TMO;
        push_read_resp(32'hA500_0000);
        send_read(32'h0001_0000);
        wait_idle("late_ack");
        checks++;
        if (last_stb_len !== TMO) begin
            errors++;
            $display("FAIL late_ack_stb_len: got %0d, required %0d", last_stb_len, TMO);
        end
    endtask

    task automatic test_hold();
        checks++;
        if (hold_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_initial: got %b, required 1", hold_o);
        end
        exp_q.push_back(RSP_OK);
        send_op(OP_GO);
        wait_idle("go");
        checks++;
        if (hold_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_g: got %b, required 0", hold_o);
        end
        exp_q.push_back(RSP_OK);
        send_op(OP_HOLD);
        wait_idle("hold");
        checks++;
        if (hold_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_after_h: got %b, required 1", hold_o);
        end
        exp_q.push_back(RSP_OK);
        send_op(OP_GO);
        exp_q.push_back(RSP_UNKNOWN);
        send_op(8'h00);
        wait_idle("unknown");
        checks++;
        if (hold_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_unknown: got %b, required 0", hold_o);
        end
    endtask

    task automatic test_backpressure();
        int n;
        ack_at   = 2;
        tx_ready = 1'b0;
        push_read_resp(32'h0000_000A);
        send_read(32'h0000_0004);
        n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({tx_valid, tx_data} !== {1'b1, RSP_OK}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got valid=%b data=0x%02h, required valid=1 data=0x4b",
                         i, tx_valid, tx_data);
            end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        tx_ready = 1'b1;
        wait_idle("stall");

        gap_en = 1'b1;
        exp_q.push_back(RSP_OK);
        send_write(32'h0000_0020, 32'h1234_5678);
        wait_idle("gap_write");
        checks++;
        if ({last_addr, last_data} !== {32'h0000_0020, 32'h1234_5678}) begin
            errors++;
            $display("FAIL gap_assemble: got addr=0x%08h data=0x%08h, required addr=0x20 data=0x12345678",
                     last_addr, last_data);
        end
        push_read_resp(32'h1234_5678);
        send_read(32'h0000_0020);
        wait_idle("gap_read");
        gap_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        ack_at = 0;
        send_read(32'h0000_0008);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (wb_strobe_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_precond_stb: got %b, required 1", wb_strobe_o);
        end
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({wb_cyc_o, wb_strobe_o, busy, hold_o, rx_ready, tx_valid} !== 6'b000110) begin
            errors++;
            $display("FAIL mid_reset: got %b, required 000110",
                     {wb_cyc_o, wb_strobe_o, busy, hold_o, rx_ready, tx_valid});
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        ack_at = 2;
        exp_q.push_back(RSP_OK);
        send_write(32'h0000_000C, 32'hCAFE_F00D);
        wait_idle("post_reset");
        checks++;
        if ({last_we, last_addr, last_data} !== {1'b1, 32'hC, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL post_reset_write: got we=%b addr=0x%08h data=0x%08h, required we=1 addr=0xc data=0xcafef00d",
                     last_we, last_addr, last_data);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int cnt;
        ack_at = 1;
        push_read_resp(32'hCAFE_F00D);
        send_read(32'h0000_000C);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!tx_valid && lat < 10);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL min_latency: got %0d cycles, required 2", lat);
        end
        cnt = 1;
        @(negedge clock);
        while (tx_valid && cnt < 10) begin
            cnt++;
            @(negedge clock);
        end
        checks++;
        if (cnt !== 5) begin
            errors++;
            $display("FAIL b2b_bytes: got %0d consecutive cycles, required 5", cnt);
        end
        checks++;
        if ({busy, rx_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b rx_ready=%b, required busy=0 rx_ready=1", busy, rx_ready);
        end
        @(posedge clock);
        #1;
        wait_idle("b2b");
        checks++;
        if (last_stb_len !== 1) begin
            errors++;
            $display("FAIL b2b_stb_len: got %0d, required 1", last_stb_len);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_timeout();
        test_hold();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200us");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_loader.md
# wb_loader

Byte-stream-to-Wishbone initiator that drives the `wb_system` backdoor slave port. It accepts host commands from a byte stream, such as a UART receiver, and turns each one into a single classic Wishbone read or write cycle. It returns status and read data on an outbound byte stream. It also owns a CPU hold line, so ROM/RAM images can be loaded while the 4-bit CPU is held in reset.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles a strobe may stay high without `wb_ack_i` before the cycle is abandoned; legal range 1..65535.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `rx_data` in 8: inbound command byte.
- `rx_valid` in 1: inbound byte present.
- `rx_ready` out 1: loader accepts a byte when `rx_valid & rx_ready`.
- `tx_data` out 8: outbound response byte.
- `tx_valid` out 1: outbound byte present.
- `tx_ready` in 1: consumer takes the byte when `tx_valid & tx_ready`.
- `wb_addr_o` out 32: Wishbone address.
- `wb_data_o` out 32: Wishbone write data.
- `wb_data_i` in 32: Wishbone read data.
- `wb_cyc_o` out 1: Wishbone cycle.
- `wb_strobe_o` out 1: Wishbone strobe.
- `wb_we_o` out 1: Wishbone write enable.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `hold_o` out 1: keeps the CPU in reset while high.
- `busy` out 1: high in every state except IDLE.

## Operation
- Opcodes (first byte of a command):
  - `0x57` 'W': write.
  - `0x52` 'R': read.
  - `0x48` 'H': set hold.
  - `0x47` 'G': clear hold.
- Command formats:
  - W: opcode, then 4 address bytes, then 4 data bytes.
  - R: opcode, then 4 address bytes.
  - H and G: opcode only.
- All multi-byte fields are little-endian (LSB first). Address and data are shifted into `wb_addr_o` and `wb_data_o`.
- Responses:
  - `0x4B` 'K': success. A read sends 'K' followed by 4 data bytes, LSB first.
  - `0x45` 'E': timeout. No data bytes follow.
  - `0x3F` '?': unknown opcode.
- States and transitions:
  - IDLE: accept an opcode.
    - W or R goes to ADDR.
    - H or G updates `hold_o`, then goes to RESP with 'K'.
    - Any other opcode goes to RESP with '?'.
  - ADDR: accept 4 bytes. After the 4th, a write goes to DATA and a read goes to BUS.
  - DATA: accept 4 bytes. After the 4th, go to BUS.
  - BUS: `wb_cyc_o`, `wb_strobe_o` and `wb_we_o` (1 for write, 0 for read) are asserted.
    - On ack: capture `wb_data_i` for a read, then go to RESP with 'K'.
    - On timeout: go to RESP with 'E'.
  - RESP: send the response byte(s), then return to IDLE.
- `rx_ready` is 1 only in IDLE, ADDR and DATA. It is driven from registered state.
- `wb_ack_i` is ignored outside BUS.
- `hold_o` changes only on H or G commands. Wishbone traffic is allowed whether or not hold is set.

## Timing
- Reset values:
  - `wb_cyc_o`, `wb_strobe_o`, `wb_we_o` = 0.
  - `wb_addr_o`, `wb_data_o` = 0.
  - `tx_valid` = 0, `tx_data` = 0.
  - `busy` = 0.
  - `hold_o` = 1.
  - State = IDLE, so `rx_ready` = 1 from the first cycle after reset.
- Bus start: `wb_cyc_o` and `wb_strobe_o` rise on the cycle after the final command byte is accepted. They stay high, with address, data and we stable, until ack or timeout.
- Ack: at the edge where `wb_ack_i` = 1 is sampled:
  - cyc and strobe are low from the next cycle;
  - read data is captured on that same edge;
  - `tx_valid` rises on that same next cycle.
- Ack in the first strobe cycle is legal. Minimum command-to-response latency is 2 cycles after the last rx byte.
- Timeout counter:
  - Clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, cyc and strobe drop on the next edge.
  - If ack arrives in the same cycle the counter reaches the limit, ack wins and the response is 'K'.
- Tx handshake: `tx_data` is held stable while `tx_valid` is high and `tx_ready` is low. Back-to-back bytes are allowed, one per cycle when `tx_ready` stays high. After the last byte is accepted, the state is IDLE on the next cycle.
- Reset mid-operation: aborts at once. cyc and strobe are 0 the cycle after reset is sampled low, partial bytes are discarded, and `hold_o` returns to 1.
- There is no inter-byte timeout on the rx side. A partial command waits indefinitely.

## Structure
- Package `wb_loader_pkg` holds:
  - the opcode and response byte constants;
  - the state enum (IDLE, ADDR, DATA, BUS, RESP);
  - the derived counter width, `$clog2(TIMEOUT_CYCLES+1)`.
- Single module, no sub-module. The byte counter (2 bits), shift registers and response sequencer are inline.
- Instantiated alongside `wb_system`:
  - the `wb_*` ports connect point-to-point;
  - `hold_o` ORs into the system's CPU reset.

## Test plan
- Write then read: send W, addr 0x00000004, data 0x0000000A; slave acks after 3 cycles.
  - tx returns 'K'.
  - R of the same address returns 'K', 0x0A, 0x00, 0x00, 0x00.
  - `wb_we_o` is 1 on the write and 0 on the read.
- Timeout: with `TIMEOUT_CYCLES` = 8 and no ack, send R, addr 0x00010000.
  - Strobe stays high exactly 8 cycles.
  - tx returns 'E' only.
  - Ack in that same 8th cycle instead yields 'K'.
- Hold control:
  - After reset `hold_o` = 1.
  - 'G' gives `hold_o` = 0 and tx 'K'.
  - 'H' gives `hold_o` = 1.
  - Byte 0x00 gives tx '?' with `hold_o` unchanged.
- Backpressure:
  - With `tx_ready` low for 5 cycles during a read response, `tx_data` holds 'K' and no bytes are lost or reordered.
  - With `rx_valid` gapped randomly, the assembled address and data are correct.
- Reset mid-cycle: pull reset low while strobe is high.
  - Next cycle: cyc = strobe = 0, IDLE, `hold_o` = 1.
  - A following W completes normally.
